// File: rtl/phy_crc_stream_tx_rx.sv
// Streaming reflected-CRC unit: TX passes payload through and appends ~CRC,
// RX absorbs payload plus CRC and compares the register against a residue.
module phy_crc_stream_tx_rx #(
  parameter int               DATA_W  = 8,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'hEDB88320,
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CRC_W-1:0]  crc_value,
  output logic              crc_done,
  output logic              crc_ok,
  output logic              busy
);

  localparam int NWORDS = CRC_W / DATA_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_APPEND = 2'd2,
    ST_RXEND  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CRC_W-1:0]   crc_r, frame_r, crc_base_s, crc_upd_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               mode_r, mode_s, accept_s, out_xfer_s;

  // One DATA_W-bit word through the LSB-first reflected LFSR, fully unrolled.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      if (r[0] ^ d[i]) begin
        r = (r >> 1) ^ POLY;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  // Handshake and stream outputs; abort and reset block any transfer.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    mode_s     = (state_r == ST_IDLE) ? mode : mode_r;
    crc_base_s = (state_r == ST_IDLE) ? INIT : crc_r;
    crc_upd_s  = crc_step(crc_base_s, in_data);
    case (state_r)
      ST_IDLE, ST_DATA: begin
        if (mode_s) begin
          in_ready  = out_ready;
          out_valid = in_valid;
          out_data  = in_data;
        end else begin
          in_ready  = 1'b1;
        end
      end
      ST_APPEND: begin
        out_valid = 1'b1;
        out_data  = frame_r[DATA_W-1:0];
        out_last  = (cnt_r == CNT_LAST);
      end
      ST_RXEND: begin
        in_ready  = 1'b0;
      end
      default: begin
        in_ready  = 1'b0;
      end
    endcase
    if (rst || abort) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      in_ready  = in_ready;
    end
    accept_s   = in_valid && in_ready;
    out_xfer_s = out_valid && out_ready;
  end

  // Next-state selection; abort overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DATA: begin
        if (accept_s && in_last) begin
          state_nxt_s = mode_s ? ST_APPEND : ST_RXEND;
        end else if (accept_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_APPEND: begin
        if (out_xfer_s && out_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_APPEND;
        end
      end
      ST_RXEND: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, CRC register, latched mode and the append shift register/counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      crc_r   <= INIT;
      frame_r <= '0;
      cnt_r   <= '0;
      mode_r  <= 1'b0;
    end else if (abort) begin
      state_r <= ST_IDLE;
      crc_r   <= INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        crc_r <= crc_upd_s;
        cnt_r <= '0;
        if (state_r == ST_IDLE) begin
          mode_r <= mode;
        end
        // F is frozen here so the appended words cannot move under backpressure.
        if (in_last && mode_s) begin
          frame_r <= ~crc_upd_s;
        end
      end else if ((state_r == ST_APPEND) && out_xfer_s) begin
        frame_r <= frame_r >> DATA_W;
        if (out_last) begin
          cnt_r <= '0;
          crc_r <= INIT;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else if (state_r == ST_RXEND) begin
        crc_r <= INIT;
      end
    end
  end

  assign crc_value = crc_r;
  assign crc_done  = (state_r == ST_RXEND);
  assign crc_ok    = (state_r == ST_RXEND) && (crc_r == RESIDUE);
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_phy_crc_stream_tx_rx.sv
// Directed bench for the streaming CRC unit: byte and nibble instances share
// stimulus; the selected instance's outputs are checked against hand-computed CRC32 values.
module tb_phy_crc_stream_tx_rx;

  logic       clk = 1'b0;
  logic       rst, mode, abort, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic        r8, v8, l8, dn8, ok8, b8;
  logic [7:0]  d8;
  logic [31:0] c8;
  logic        r4, v4, l4, dn4, ok4, b4;
  logic [3:0]  d4;
  logic [31:0] c4;

  bit          w4;
  logic        s_rdy, s_vld, s_last, s_done, s_ok, s_busy;
  logic [7:0]  s_data;
  logic [31:0] s_crc;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] msg [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                           8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

  always #5 clk = ~clk;

  phy_crc_stream_tx_rx #(.DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_ready(r8), .in_data(in_data), .in_last(in_last),
    .out_valid(v8), .out_ready(out_ready), .out_data(d8), .out_last(l8),
    .crc_value(c8), .crc_done(dn8), .crc_ok(ok8), .busy(b8));

  phy_crc_stream_tx_rx #(.DATA_W(4)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_ready(r4), .in_data(in_data[3:0]), .in_last(in_last),
    .out_valid(v4), .out_ready(out_ready), .out_data(d4), .out_last(l4),
    .crc_value(c4), .crc_done(dn4), .crc_ok(ok4), .busy(b4));

  always_comb begin
    s_rdy  = w4 ? r4 : r8;
    s_vld  = w4 ? v4 : v8;
    s_data = w4 ? {4'h0, d4} : d8;
    s_last = w4 ? l4 : l8;
    s_crc  = w4 ? c4 : c8;
    s_done = w4 ? dn4 : dn8;
    s_ok   = w4 ? ok4 : ok8;
    s_busy = w4 ? b4 : b8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] word_of(input int i, input bit flip);
    int         bi;
    logic [7:0] b;
    bi = w4 ? i / 2 : i;
    b  = msg[bi];
    if (flip && bi == 3) b = b ^ 8'h01;
    if (w4) return (i % 2 == 1) ? {4'h0, b[7:4]} : {4'h0, b[3:0]};
    return b;
  endfunction

  task automatic send_word(input logic [7:0] d, input bit last, input bit tx);
    @(negedge clk);
    mode = tx; in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    chk("in_ready", s_rdy, 1);
    if (tx) begin
      chk("pass_valid", s_vld, 1);
      chk("pass_data", s_data, d);
      chk("pass_last", s_last, 0);
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_frame(input int nbytes, input bit tx, input bit flip);
    int nw;
    nw = w4 ? 2 * nbytes : nbytes;
    for (int i = 0; i < nw; i++) send_word(word_of(i, flip), (i == nw - 1), tx);
    idle_in();
  endtask

  task automatic check_rx(input bit exp_ok);
    #1;
    chk("rx_done", s_done, 1);
    chk("rx_ok", s_ok, exp_ok);
    if (exp_ok) chk("rx_residue", s_crc, 32'hDEBB20E3);
    @(negedge clk); #1;
    chk("rx_done_pulse", s_done, 0);
    chk("rx_idle", s_busy, 0);
  endtask

  task automatic check_append(input bit stall);
    logic [31:0] f;
    logic [7:0]  exp;
    bit   [3:0]  pat;
    int n, dw, k, c;
    f = 32'hCBF43926; pat = 4'b1001;
    n = w4 ? 8 : 4; dw = w4 ? 4 : 8;
    k = 0; c = 0;
    #1;
    chk("crc_pre_inv", s_crc, 32'h340BC6D9);
    while (k < n && c < 40) begin
      if (c > 0) @(negedge clk);
      out_ready = stall ? pat[c % 4] : 1'b1;
      #1;
      exp = 8'((f >> (k * dw)) & (w4 ? 32'h0000000F : 32'h000000FF));
      chk("ap_valid", s_vld, 1);
      chk("ap_data", s_data, exp);
      chk("ap_last", s_last, (k == n - 1));
      if (out_ready) k++;
      c++;
      @(posedge clk);
    end
    chk("ap_count", k, n);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("ap_busy_drop", s_busy, 0);
    chk("ap_no_valid", s_vld, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    w4 = 1'b0;
    rst = 1'b1; mode = 1'b1; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; #1;
    chk("rst_in_ready", s_rdy, 0);
    chk("rst_out_valid", s_vld, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_crc", s_crc, 32'hFFFFFFFF);
    chk("rst_done", s_done, 0);
    chk("rst_ok", s_ok, 0);
    in_valid = 1'b0; rst = 1'b0;

    send_frame(9, 1'b1, 1'b0);
    check_append(1'b0);
    send_frame(13, 1'b0, 1'b0);
    check_rx(1'b1);
    send_frame(13, 1'b0, 1'b1);
    check_rx(1'b0);
    send_frame(9, 1'b1, 1'b0);
    check_append(1'b1);

    // Abort on the fifth payload word, then a clean frame.
    for (int i = 0; i < 4; i++) send_word(msg[i], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = msg[4]; abort = 1'b1; #1;
    chk("abort_in_ready", s_rdy, 0);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; #1;
    chk("abort_busy", s_busy, 0);
    chk("abort_crc", s_crc, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("abort_no_done", s_done, 0);
    end
    send_frame(13, 1'b0, 1'b0);
    check_rx(1'b1);

    // Reset after the first CRC word of a TX frame.
    send_frame(9, 1'b1, 1'b0);
    #1;
    chk("rstap_valid", s_vld, 1);
    chk("rstap_data", s_data, 8'h26);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rstap_in_ready", s_rdy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rstap_busy", s_busy, 0);
    chk("rstap_valid_off", s_vld, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rstap_quiet", s_vld, 0);
    end

    // Nibble instance, same frame low nibble first.
    pulse_reset();
    w4 = 1'b1;
    send_frame(9, 1'b1, 1'b0);
    check_append(1'b0);
    send_frame(13, 1'b0, 1'b0);
    check_rx(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
